// File: rtl/spike_rate_encoder_if.sv
// Handshake and spike-output bundle between the data loader, the encoder and a neuron's i_spike port.
// Latency: none, wires only.
// Backpressure: o_ready from the encoder gates i_valid/i_intensity from the loader.
interface spike_rate_encoder_if #(
  parameter int INTENSITY_W = 8,
  parameter int DATA_LENGTH = 32
);
  logic                   i_valid;
  logic                   o_ready;
  logic [INTENSITY_W-1:0] i_intensity;
  logic [DATA_LENGTH-1:0] o_spike;
  logic                   o_spike_flag;
  logic                   o_busy;
  logic                   o_done;
  logic [15:0]            o_spike_count;

  // Loader side: offers samples and watches the spike stream
  modport master (
    output i_valid, i_intensity,
    input  o_ready, o_spike, o_spike_flag, o_busy, o_done, o_spike_count
  );

  // Encoder side
  modport slave (
    input  i_valid, i_intensity,
    output o_ready, o_spike, o_spike_flag, o_busy, o_done, o_spike_count
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate encoder: one intensity sample in, WINDOW cycles of weighted spikes out, rate proportional to intensity.
// Latency: spikes appear 1 cycle after accept for WINDOW cycles; o_done pulses WINDOW+1 cycles after accept.
// Backpressure: o_ready low from accept until the o_done cycle; one sample per WINDOW+2 cycles.
// Build option SPK_ENC_DETERMINISTIC_EN: phase accumulator (exact count) instead of the stochastic LFSR.
module spike_rate_encoder #(
  parameter int                     DATA_LENGTH  = 32,
  parameter int                     INTENSITY_W  = 8,
  parameter int                     WINDOW       = 256,
  parameter logic [DATA_LENGTH-1:0] SPIKE_WEIGHT = 429496729,
  parameter logic [15:0]            LFSR_SEED    = 16'hACE1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  spike_rate_encoder_if.slave bus
);

  localparam int              CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [INTENSITY_W-1:0] intensity, intensity_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [15:0]            count, count_nxt;
  logic [DATA_LENGTH-1:0] spike, spike_nxt;
  logic                   flag, flag_nxt;
  logic                   ready, ready_nxt;
  logic                   busy, busy_nxt;
  logic                   done, done_nxt;
  logic                   hit;
  logic                   accept;

  assign accept = (state == IDLE) && bus.i_valid && ready;

`ifdef SPK_ENC_DETERMINISTIC_EN
  logic [INTENSITY_W-1:0] acc;
  logic [INTENSITY_W:0]   acc_sum;

  // Phase accumulator: the carry out of acc + intensity marks a spike, giving evenly spaced hits
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, intensity};
    hit     = acc_sum[INTENSITY_W];
  end

  // Accumulator restarts at each accept and steps once per RUN cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          acc <= '0;
    else if (accept)       acc <= '0;
    else if (state == RUN) acc <= acc_sum[INTENSITY_W-1:0];
  end
`else
  // A zero seed would lock the LFSR at zero forever
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;

  // Stochastic hit: uniform LFSR slice below the intensity threshold
  always_comb hit = (lfsr[INTENSITY_W-1:0] < intensity);

  // Galois LFSR, free-running across windows, advanced only in RUN so the sequence is reproducible
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          lfsr <= SEED;
    else if (state == RUN) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next registered-output values
  always_comb begin
    state_nxt     = state;
    intensity_nxt = intensity;
    cnt_nxt       = cnt;
    count_nxt     = count;
    spike_nxt     = spike;
    flag_nxt      = flag;
    ready_nxt     = ready;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        spike_nxt = '0;
        flag_nxt  = 1'b0;
        if (accept) begin
          intensity_nxt = bus.i_intensity;
          cnt_nxt       = '0;
          count_nxt     = '0;
          ready_nxt     = 1'b0;
          busy_nxt      = 1'b1;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        spike_nxt = hit ? SPIKE_WEIGHT : '0;
        flag_nxt  = hit;
        if (hit) count_nxt = count + 16'd1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        spike_nxt = '0;
        flag_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      intensity <= '0;
      cnt       <= '0;
      count     <= '0;
      spike     <= '0;
      flag      <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      intensity <= intensity_nxt;
      cnt       <= cnt_nxt;
      count     <= count_nxt;
      spike     <= spike_nxt;
      flag      <= flag_nxt;
      ready     <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_spike       = spike;
  assign bus.o_spike_flag  = flag;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_spike_count = count;

endmodule
